// File: rtl/byte_serial_add_seq.sv
// Byte-serial modular adder: adds two NB-byte operands LSB byte first through a
// single 8-bit slice, with an optional running accumulator used as operand B.
module byte_serial_add_seq #(
  parameter int NB = 4,
  localparam int W = 8 * NB
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         acc_en,
  input  logic         acc_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         busy
);

  localparam int CW = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_nxt;
  logic [W-1:0]   a_q, b_q, acc_q, result_q, result_nxt;
  logic [CW-1:0]  cnt_q;
  logic           carry_q, carry_out_q, acc_en_q;
  logic [7:0]     a_byte, b_byte;
  logic [8:0]     byte_sum;
  logic           last_byte, accept;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready depends only on state, so there is no input-to-output path.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid && in_ready;
  assign result    = result_q;
  assign carry_out = carry_out_q;

  always_comb begin
    a_byte     = a_q[{cnt_q, 3'b000} +: 8];
    b_byte     = b_q[{cnt_q, 3'b000} +: 8];
    byte_sum   = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, carry_q};
    last_byte  = (cnt_q == CW'(NB - 1));
    result_nxt = result_q;
    result_nxt[{cnt_q, 3'b000} +: 8] = byte_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (accept) state_nxt = ADD;
      ADD:     if (last_byte) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      acc_en_q    <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        if (acc_clr) acc_q <= '0;
        if (accept) begin
          a_q      <= op_a;
          // A clear on the accepting edge must also zero the B operand it feeds.
          b_q      <= acc_en ? (acc_clr ? '0 : acc_q) : op_b;
          acc_en_q <= acc_en;
          carry_q  <= 1'b0;
          cnt_q    <= '0;
        end
      end
      if (state_q == ADD) begin
        result_q <= result_nxt;
        carry_q  <= byte_sum[8];
        cnt_q    <= last_byte ? '0 : cnt_q + CW'(1);
        if (last_byte) begin
          carry_out_q <= byte_sum[8];
          if (acc_en_q) acc_q <= result_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_byte_serial_add_seq.sv
// Randomized bench for byte_serial_add_seq against an arithmetic reference model
// of the modular sum and the accumulator.
module tb_byte_serial_add_seq;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk, rst_n;
  logic         in_valid, in_ready, acc_en, acc_clr;
  logic         out_valid, out_ready, carry_out, busy;
  logic [W-1:0] op_a, op_b, result;

  int n_cmp = 0;
  int n_err = 0;
  logic [W:0]   exp_q[$];
  logic [W-1:0] acc_m;

  byte_serial_add_seq #(.NB(NB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry_out(carry_out), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: B is op_b, or the accumulator (zero when cleared on the same
  // accept); sum is plain W+1-bit addition, accumulator keeps the low W bits.
  task automatic model_req(input logic [W-1:0] a, b, input logic en, clr);
    logic [W-1:0] bsrc;
    logic [W:0]   sum;
    bsrc = en ? (clr ? '0 : acc_m) : b;
    sum  = {1'b0, a} + {1'b0, bsrc};
    if (en) acc_m = sum[W-1:0];
    else if (clr) acc_m = '0;
    exp_q.push_back(sum);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    acc_clr = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    acc_clr = 1'b0;
    acc_m = '0;
  endtask

  // driver: one request, optional back-pressure of `hold` cycles in DONE
  task automatic do_req(input logic [W-1:0] a, b, input logic en, clr, input int hold);
    logic [W:0] e;
    int k;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_wait", in_ready, 1);
    op_a = a; op_b = b; acc_en = en; acc_clr = clr; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; acc_clr = 1'b0;
    acc_en = 1'($urandom); op_a = $urandom; op_b = $urandom;
    model_req(a, b, en, clr);
    for (int i = 1; i <= NB + 1; i++) begin
      @(negedge clk);
      check("out_valid_latency", out_valid, (i == NB + 1));
      if (i <= NB) check("busy_in_add", {busy, in_ready}, 2'b10);
    end
    e = exp_q.pop_front();
    check("result", {carry_out, result}, e);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom); op_a = $urandom; op_b = $urandom;
      acc_en = 1'($urandom); acc_clr = 1'($urandom);
      @(negedge clk);
      check("hold_result", {carry_out, result}, e);
      check("hold_flags", {out_valid, in_ready, busy}, 3'b101);
    end
    in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("post_hs_flags", {out_valid, in_ready, busy}, 3'b010);
    check("idle_result_held", {carry_out, result}, e);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    out_ready = 1'b0; op_a = '0; op_b = '0; acc_m = '0;
    repeat (3) @(negedge clk);
    check("reset_flags", {in_ready, out_valid, busy}, 3'b100);
    check("reset_result", {carry_out, result}, '0);
    rst_n = 1'b1;

    // basic add, full-ripple wrap
    do_req(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
    do_req(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);

    // accumulate chain; carry not fed back
    pulse_clr();
    do_req(32'h8000_0000, $urandom, 1'b1, 1'b0, 0);
    do_req(32'h8000_0000, $urandom, 1'b1, 1'b0, 0);
    do_req(32'h1234_5678, $urandom, 1'b1, 1'b0, 0);
    do_req(32'h0000_0000, $urandom, 1'b1, 1'b0, 0);

    // back-pressure in DONE with noisy inputs
    do_req(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0, 6);

    // clear coinciding with accumulate accept
    pulse_clr();
    do_req(32'h0000_0055, $urandom, 1'b1, 1'b0, 0);
    do_req(32'h0000_AAAA, $urandom, 1'b1, 1'b1, 0);

    // async reset mid-operation
    @(negedge clk);
    op_a = 32'h0101_0101; op_b = 32'h0202_0202; acc_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midreset_flags", {out_valid, busy, in_ready}, 3'b001);
    acc_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midreset_no_out", out_valid, 1'b0);
    end
    do_req(32'h0000_0005, $urandom, 1'b1, 1'b0, 0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic en, clr;
      en  = ($urandom_range(0, 2) == 0);
      clr = en && ($urandom_range(0, 4) == 0);
      do_req($urandom, $urandom, en, clr, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
